// File: rtl/adc_trig_capture.sv
// adc_trig_capture
//
// Triggered capture buffer for the offset-corrected signed sample stream.
// Samples are written into a circular RAM. A level crossing (rising or
// falling) or a forced trigger freezes a DEPTH-sample window made of pre_len
// samples before the trigger, then the trigger sample and the samples after
// it. The window is read out sequentially, oldest sample first.
//
// Optional feature: define CAPTURE_TIMEOUT_EN to build an auto-trigger that
// fires TIMEOUT cycles after entering ARMED and sets timed_out. Without the
// macro, ARMED waits forever and timed_out is tied to 0.
//
// Ports:
//   CLK_SAMPLE  in   sample clock, rising-edge active
//   RST_N       in   asynchronous active-low reset
//   s_data_in   in   signed sample, valid every cycle
//   arm         in   one-cycle pulse, starts/restarts a capture
//   trig_level  in   signed trigger threshold
//   trig_slope  in   1 = rising crossing, 0 = falling crossing
//   force_trig  in   immediate trigger, honoured only in ARMED
//   pre_len     in   pre-trigger sample count, latched on arm
//   rd_req      in   read one sample, honoured only in DONE
//   busy        out  high in PREFILL, ARMED and POST
//   done        out  high in DONE
//   rd_valid    out  rd_data valid (one cycle after rd_req)
//   rd_data     out  signed sample read from the buffer
//   rd_last     out  high with rd_valid on the DEPTH-th sample
//   timed_out   out  last capture was auto-triggered
module adc_trig_capture #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned AW      = 10,
   parameter int unsigned DW      = 12,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic                 CLK_SAMPLE,
   input  logic                 RST_N,
   input  logic signed [DW-1:0] s_data_in,
   input  logic                 arm,
   input  logic signed [DW-1:0] trig_level,
   input  logic                 trig_slope,
   input  logic                 force_trig,
   input  logic        [AW-1:0] pre_len,
   input  logic                 rd_req,
   output logic                 busy,
   output logic                 done,
   output logic                 rd_valid,
   output logic signed [DW-1:0] rd_data,
   output logic                 rd_last,
   output logic                 timed_out
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREFILL,
      ST_ARMED,
      ST_POST,
      ST_DONE
   } state_e;

   state_e state_q, state_d;

   logic        [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic        [AW-1:0] cnt_q, cnt_d;
   logic        [AW-1:0] pre_len_q, pre_len_d;
   logic        [AW-1:0] trig_ptr_q, trig_ptr_d;
   logic        [AW:0]   post_cnt_q, post_cnt_d;
   logic        [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic        [AW-1:0] rd_cnt_q, rd_cnt_d;
   logic signed [DW-1:0] prev_q, prev_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 rd_last_q, rd_last_d;
   logic signed [DW-1:0] rd_data_q;

   logic                 wr_en;
   logic                 rd_en;
   logic                 level_hit;
   logic                 trig_hit;
   logic        [AW:0]   post_len;

   logic        [DW-1:0] mem [DEPTH];

   // Samples to take from the trigger onwards, trigger sample included.
   // pre_len is AW bits wide, so it can never exceed DEPTH-1 and needs no
   // further clamping.
   assign post_len = (AW+1)'(DEPTH) - (AW+1)'(pre_len_q);

   assign level_hit = trig_slope ? ((prev_q <  trig_level) && (s_data_in >= trig_level))
                                 : ((prev_q >  trig_level) && (s_data_in <= trig_level));

`ifdef CAPTURE_TIMEOUT_EN
   localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

   logic [15:0] to_cnt_q, to_cnt_d;
   logic        timed_out_q, timed_out_d;
   logic        auto_trig;

   // Counter is held at zero outside ARMED, so every entry starts from zero.
   always_comb begin
      to_cnt_d    = '0;
      timed_out_d = timed_out_q;
      auto_trig   = 1'b0;
      if (arm) begin
         timed_out_d = 1'b0;
      end else if (state_q == ST_ARMED) begin
         to_cnt_d  = to_cnt_q + 16'd1;
         auto_trig = (to_cnt_d == TO_LIMIT);
         if (auto_trig) begin
            timed_out_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK_SAMPLE or negedge RST_N) begin
      if (!RST_N) begin
         to_cnt_q    <= '0;
         timed_out_q <= 1'b0;
      end else begin
         to_cnt_q    <= to_cnt_d;
         timed_out_q <= timed_out_d;
      end
   end

   assign trig_hit  = level_hit | force_trig | auto_trig;
   assign timed_out = timed_out_q;
`else
   assign trig_hit  = level_hit | force_trig;
   assign timed_out = 1'b0;
`endif

   // State register
   always_ff @(posedge CLK_SAMPLE or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath updates; arm overrides everything, including a
   // simultaneous rd_req.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      cnt_d      = cnt_q;
      pre_len_d  = pre_len_q;
      trig_ptr_d = trig_ptr_q;
      post_cnt_d = post_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      rd_cnt_d   = rd_cnt_q;
      prev_d     = s_data_in;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;

      if (arm) begin
         pre_len_d = pre_len;
         wr_ptr_d  = '0;
         cnt_d     = '0;
         state_d   = (pre_len != '0) ? ST_PREFILL : ST_ARMED;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
            end
            ST_PREFILL: begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               cnt_d    = cnt_q + 1'b1;
               if ((cnt_q + 1'b1) == pre_len_q) begin
                  state_d = ST_ARMED;
               end
            end
            ST_ARMED: begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (trig_hit) begin
                  trig_ptr_d = wr_ptr_q;
                  post_cnt_d = (AW+1)'(1);
                  state_d    = ST_POST;
               end
            end
            ST_POST: begin
               // The last sample was written on the previous edge; this
               // cycle only moves to DONE, giving DEPTH-pre_len cycles from
               // trigger to done.
               if (post_cnt_q == post_len) begin
                  rd_ptr_d = trig_ptr_q - pre_len_q;
                  rd_cnt_d = '0;
                  state_d  = ST_DONE;
               end else begin
                  wr_en      = 1'b1;
                  wr_ptr_d   = wr_ptr_q + 1'b1;
                  post_cnt_d = post_cnt_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (rd_req) begin
                  rd_en      = 1'b1;
                  rd_valid_d = 1'b1;
                  rd_ptr_d   = rd_ptr_q + 1'b1;
                  rd_cnt_d   = rd_cnt_q + 1'b1;
                  if (rd_cnt_q == AW'(DEPTH - 1)) begin
                     rd_last_d = 1'b1;
                     state_d   = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output decode
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         ST_PREFILL, ST_ARMED, ST_POST: busy = 1'b1;
         ST_DONE:                       done = 1'b1;
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK_SAMPLE or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
         pre_len_q  <= '0;
         trig_ptr_q <= '0;
         post_cnt_q <= '0;
         rd_ptr_q   <= '0;
         rd_cnt_q   <= '0;
         prev_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         cnt_q      <= cnt_d;
         pre_len_q  <= pre_len_d;
         trig_ptr_q <= trig_ptr_d;
         post_cnt_q <= post_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_cnt_q   <= rd_cnt_d;
         prev_q     <= prev_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
      end
   end

   // RAM write port
   always_ff @(posedge CLK_SAMPLE) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= s_data_in;
      end
   end

   // RAM read port; the array is read directly here (not via a _d term) so
   // the read stays synchronous and maps onto a block RAM output register.
   always_ff @(posedge CLK_SAMPLE or negedge RST_N) begin
      if (!RST_N) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem[rd_ptr_q];
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_last  = rd_last_q;
   assign rd_data  = rd_data_q;

endmodule
